mole_round_ctrl: RTL and testbench
==================================

# mole_round_ctrl

Game-round sequencer for Whack-a-Mole on Basys 3. Derives a 100 Hz tick enable from the 100 MHz system clock and schedules the game on that tick: it runs the 30 s round timer, picks a pseudo-random hole, and lights it for a bounded on-time. It also scores button hits. Button, LED and seven-segment logic connect to it. No derived clocks; everything runs in the `clk` domain.

## Interface
- `TICK_DIV`, 1_000_000: system clocks per tick (100 Hz at 100 MHz).
- `GAME_TICKS`, 3000: round length in ticks (30 s).
- `MOLE_TICKS`, 100: mole on-time in ticks.
- `GAP_TICKS`, 20: blank time between moles, in ticks.
- `NUM_HOLES`, 4: hole count, power of two, 2..16.
- `clk  in  1`: 100 MHz system clock.
- `reset  in  1`: synchronous, active-high.
- `start  in  1`: one-cycle pulse, debounced upstream.
- `btn  in  NUM_HOLES`: one-cycle hit pulses, debounced upstream.
- `mole  out  NUM_HOLES`: one-hot active hole, or 0.
- `score  out  8`: hits this round, saturates at 255.
- `time_left  out  12`: ticks remaining in the round.
- `playing  out  1`: high in GAP/SHOW.
- `game_over  out  1`: high in OVER.
- `tick  out  1`: one-cycle 100 Hz enable, for display refresh.

## Operation
- Reset values, applied on the cycle after `reset` is sampled high:
  - state IDLE; `mole`=0, `score`=0, `time_left`=0, `playing`=0, `game_over`=0, `tick`=0.
  - Tick counter 0; LFSR 16'hACE1.
- Tick generator: counter runs 0..TICK_DIV-1 and wraps. `tick`=1 in exactly one cycle per TICK_DIV cycles, while counter==TICK_DIV-1. It is free-running in all states.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances every `clk` cycle. Hole index = low log2(NUM_HOLES) bits.
- States: IDLE, GAP, SHOW, OVER.
  - IDLE/OVER + `start` → GAP. Load `score`=0, `time_left`=GAME_TICKS, gap_cnt=GAP_TICKS.
  - GAP: on each `tick`, gap_cnt−1. At `tick` with gap_cnt==1 → SHOW. `mole` = one-hot(current index); mole_cnt=MOLE_TICKS.
  - SHOW, `btn & mole` ≠ 0 → GAP. `mole`=0; `score`+1, saturating; gap_cnt=GAP_TICKS. A multi-button press that includes the lit hole scores once. Wrong buttons are ignored.
  - SHOW: on each `tick`, mole_cnt−1. At `tick` with mole_cnt==1 and no hit → GAP. `mole`=0; gap_cnt=GAP_TICKS. No penalty.
  - GAP/SHOW: on each `tick`, `time_left`−1. At `tick` with `time_left`==1 → OVER. `mole`=0 and `time_left`=0. This has priority over the GAP/SHOW transitions.
- `start` during GAP/SHOW is ignored.
- `btn` outside SHOW is ignored.

## Timing
- All outputs are registered. Changes appear the cycle after the causing input or `tick`.
- `start` → `playing`=1, `time_left`=GAME_TICKS after 1 cycle.
- The first mole appears GAP_TICKS ticks after start. The first counted tick is the first `tick` after entering GAP.
- A hit clears `mole` and bumps `score` 1 cycle after the `btn` pulse.
- Hit in the same cycle as the timeout tick: the hit wins (score+1, GAP).
- Hit in the same cycle as the final round tick: score+1 and → OVER.
- Tick during GAP/SHOW entry cycle: that tick is not counted by the new gap/mole counter. It is counted by `time_left` if already playing.
- Reset mid-round aborts immediately to reset values. No partial score is retained.

## Structure
- Shared package `mole_pkg`:
  - state enum (IDLE, GAP, SHOW, OVER);
  - LFSR seed 16'hACE1 and tap constants;
  - default TICK_DIV for the 100 MHz clock.
- Sub-module `tick_gen`: TICK_DIV counter that emits the `tick` enable. It replaces the divided-clock approach, so all game logic stays on `clk`.
- FSM, counters, LFSR and scoring stay in `mole_round_ctrl`.

## Test plan
Parameters for the bench: TICK_DIV=4, GAME_TICKS=20, MOLE_TICKS=3, GAP_TICKS=2, NUM_HOLES=4.
- Reset, then idle 40 cycles:
  - `tick` pulses every 4 cycles; `mole`=0; `playing`=0; `score`=0.
- `start` pulse:
  - next cycle `playing`=1, `time_left`=20;
  - `mole` becomes one-hot after exactly 2 ticks.
- `btn` equal to the lit `mole`:
  - next cycle `mole`=0, `score`=1;
  - a new mole appears after 2 more ticks.
- Wrong `btn` during SHOW, or `btn` during GAP:
  - `score` unchanged;
  - in the wrong-button case `mole` clears after 3 ticks.
- Run 20 ticks after start, including a correct hit coinciding with the final tick:
  - `score` counts that hit;
  - `game_over`=1, `mole`=0, `time_left`=0;
  - a further `start` restarts with `score`=0.
- Force 256 hits, then assert `reset` mid-SHOW:
  - `score` holds at 255;
  - after reset all outputs return to reset values.

Source files
------------

// File: rtl/mole_pkg.sv
// Shared types and constants for the whack-a-mole round sequencer.
package mole_pkg;

    // Round sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GAP  = 2'd1,
        ST_SHOW = 2'd2,
        ST_OVER = 2'd3
    } state_t;

    localparam int unsigned LFSR_W       = 16;
    localparam int unsigned SCORE_W      = 8;
    localparam int unsigned TIME_W       = 12;
    localparam int unsigned DEF_TICK_DIV = 1_000_000;

    // Fibonacci LFSR seed and feedback mask (taps 16,14,13,11 -> bits 15,13,12,10)
    localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/mole_round_ctrl_tick_gen.sv
// Free-running divider producing a one-cycle tick enable every TICK_DIV clocks.
module tick_gen
    import mole_pkg::*;
#(
    parameter int unsigned TICK_DIV = DEF_TICK_DIV
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_d;

    // Next count value, wrapping at TICK_DIV-1
    always_comb begin
        cnt_d = cnt + CW'(1);
        if (cnt == LAST) begin
            cnt_d = '0;
        end
    end

    // Counter and registered tick, high exactly while the counter holds LAST
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            cnt  <= cnt_d;
            tick <= (cnt_d == LAST);
        end
    end

endmodule

// File: rtl/mole_round_ctrl.sv
// Whack-a-mole round sequencer: round timer, random hole selection, mole timing and scoring.
module mole_round_ctrl
    import mole_pkg::*;
#(
    parameter int unsigned TICK_DIV   = DEF_TICK_DIV,
    parameter int unsigned GAME_TICKS = 3000,
    parameter int unsigned MOLE_TICKS = 100,
    parameter int unsigned GAP_TICKS  = 20,
    parameter int unsigned NUM_HOLES  = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [NUM_HOLES-1:0] btn,
    output logic [NUM_HOLES-1:0] mole,
    output logic [SCORE_W-1:0]   score,
    output logic [TIME_W-1:0]    time_left,
    output logic                 playing,
    output logic                 game_over,
    output logic                 tick
);

    localparam int unsigned IW = $clog2(NUM_HOLES);
    localparam int unsigned GW = $clog2(GAP_TICKS + 1);
    localparam int unsigned MW = $clog2(MOLE_TICKS + 1);

    state_t                state;
    state_t                state_d;
    logic [NUM_HOLES-1:0]  mole_d;
    logic [SCORE_W-1:0]    score_d;
    logic [TIME_W-1:0]     time_d;
    logic [GW-1:0]         gap_cnt;
    logic [GW-1:0]         gap_d;
    logic [MW-1:0]         mole_cnt;
    logic [MW-1:0]         mole_cnt_d;
    logic [LFSR_W-1:0]     lfsr;
    logic [LFSR_W-1:0]     lfsr_d;
    logic [NUM_HOLES-1:0]  pick_c;
    logic                  hit_c;
    logic                  final_c;

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    // LFSR step and one-hot hole selection from its low bits
    always_comb begin
        lfsr_d = {lfsr[LFSR_W-2:0], ^(lfsr & LFSR_TAPS)};
        pick_c = NUM_HOLES'(1) << lfsr[IW-1:0];
    end

    // Next-state and datapath updates; round end outranks hit, hit outranks mole timeout
    always_comb begin
        state_d    = state;
        mole_d     = mole;
        score_d    = score;
        time_d     = time_left;
        gap_d      = gap_cnt;
        mole_cnt_d = mole_cnt;
        hit_c      = (state == ST_SHOW) && (|(btn & mole));
        final_c    = tick && (time_left == TIME_W'(1));

        case (state)
            ST_IDLE, ST_OVER: begin
                if (start) begin
                    state_d = ST_GAP;
                    mole_d  = '0;
                    score_d = '0;
                    time_d  = TIME_W'(GAME_TICKS);
                    gap_d   = GW'(GAP_TICKS);
                end
            end

            ST_GAP: begin
                if (tick) begin
                    time_d = time_left - TIME_W'(1);
                    if (final_c) begin
                        state_d = ST_OVER;
                        mole_d  = '0;
                        time_d  = '0;
                    end else if (gap_cnt == GW'(1)) begin
                        state_d    = ST_SHOW;
                        mole_d     = pick_c;
                        mole_cnt_d = MW'(MOLE_TICKS);
                    end else begin
                        gap_d = gap_cnt - GW'(1);
                    end
                end
            end

            ST_SHOW: begin
                if (hit_c && (score != '1)) begin
                    score_d = score + SCORE_W'(1);
                end
                if (tick) begin
                    time_d = time_left - TIME_W'(1);
                end
                if (final_c) begin
                    state_d = ST_OVER;
                    mole_d  = '0;
                    time_d  = '0;
                end else if (hit_c) begin
                    state_d = ST_GAP;
                    mole_d  = '0;
                    gap_d   = GW'(GAP_TICKS);
                end else if (tick) begin
                    if (mole_cnt == MW'(1)) begin
                        state_d = ST_GAP;
                        mole_d  = '0;
                        gap_d   = GW'(GAP_TICKS);
                    end else begin
                        mole_cnt_d = mole_cnt - MW'(1);
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                mole_d  = '0;
            end
        endcase
    end

    // State, counters, LFSR and registered status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            mole      <= '0;
            score     <= '0;
            time_left <= '0;
            gap_cnt   <= '0;
            mole_cnt  <= '0;
            lfsr      <= LFSR_SEED;
            playing   <= 1'b0;
            game_over <= 1'b0;
        end else begin
            state     <= state_d;
            mole      <= mole_d;
            score     <= score_d;
            time_left <= time_d;
            gap_cnt   <= gap_d;
            mole_cnt  <= mole_cnt_d;
            lfsr      <= lfsr_d;
            playing   <= (state_d == ST_GAP) || (state_d == ST_SHOW);
            game_over <= (state_d == ST_OVER);
        end
    end

endmodule

// File: tb/tb_mole_round_ctrl.sv
// Bench for mole_round_ctrl: directed scenarios plus random play against a behavioural game model.
module tb_mole_round_ctrl;

    localparam int TB_DIV  = 4;
    localparam int TB_GAME = 20;
    localparam int TB_MOLE = 3;
    localparam int TB_GAP  = 2;

    localparam int P_IDLE = 0;
    localparam int P_GAP  = 1;
    localparam int P_SHOW = 2;
    localparam int P_OVER = 3;

    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  btn;
    logic [3:0]  mole;
    logic [7:0]  score;
    logic [11:0] time_left;
    logic        playing;
    logic        game_over;
    logic        tick;

    logic        rst2;
    logic        start2;
    logic [7:0]  btn2;
    logic [7:0]  mole2;
    logic [7:0]  score2;
    logic [11:0] time2;
    logic        playing2;
    logic        over2;
    logic        tick2;

    int n_total;
    int n_bad;

    // Behavioural model of the main instance
    int          m_phase;
    int          m_score;
    int          m_time;
    int          m_gap;
    int          m_mcnt;
    int          m_div;
    bit          m_tick;
    logic [3:0]  m_mole;
    logic [15:0] m_lfsr;

    mole_round_ctrl #(
        .TICK_DIV   (TB_DIV),
        .GAME_TICKS (TB_GAME),
        .MOLE_TICKS (TB_MOLE),
        .GAP_TICKS  (TB_GAP),
        .NUM_HOLES  (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .btn       (btn),
        .mole      (mole),
        .score     (score),
        .time_left (time_left),
        .playing   (playing),
        .game_over (game_over),
        .tick      (tick)
    );

    // Long round with short gaps so the score can be driven to saturation
    mole_round_ctrl #(
        .TICK_DIV   (2),
        .GAME_TICKS (4000),
        .MOLE_TICKS (3),
        .GAP_TICKS  (1),
        .NUM_HOLES  (8)
    ) dut_sat (
        .clk       (clk),
        .reset     (rst2),
        .start     (start2),
        .btn       (btn2),
        .mole      (mole2),
        .score     (score2),
        .time_left (time2),
        .playing   (playing2),
        .game_over (over2),
        .tick      (tick2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock edge of the game rules, using the inputs present at that edge
    function automatic void model_edge();
        bit t;
        bit h;
        if (reset) begin
            m_phase = P_IDLE;
            m_score = 0;
            m_time  = 0;
            m_gap   = 0;
            m_mcnt  = 0;
            m_mole  = 4'd0;
            m_lfsr  = 16'hACE1;
            m_div   = 0;
            m_tick  = 1'b0;
            return;
        end
        t = m_tick;
        h = (m_phase == P_SHOW) && ((btn & m_mole) != 4'd0);
        if (m_phase == P_IDLE || m_phase == P_OVER) begin
            if (start) begin
                m_phase = P_GAP;
                m_score = 0;
                m_time  = TB_GAME;
                m_gap   = TB_GAP;
                m_mole  = 4'd0;
            end
        end else begin
            if (h) m_score = (m_score >= 255) ? 255 : m_score + 1;
            if (t) m_time = m_time - 1;
            if (t && m_time == 0) begin
                m_phase = P_OVER;
                m_mole  = 4'd0;
            end else if (h) begin
                m_phase = P_GAP;
                m_mole  = 4'd0;
                m_gap   = TB_GAP;
            end else if (t) begin
                if (m_phase == P_GAP) begin
                    m_gap = m_gap - 1;
                    if (m_gap == 0) begin
                        m_phase = P_SHOW;
                        m_mole  = 4'd1 << m_lfsr[1:0];
                        m_mcnt  = TB_MOLE;
                    end
                end else begin
                    m_mcnt = m_mcnt - 1;
                    if (m_mcnt == 0) begin
                        m_phase = P_GAP;
                        m_mole  = 4'd0;
                        m_gap   = TB_GAP;
                    end
                end
            end
        end
        m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
        m_div  = (m_div + 1) % TB_DIV;
        m_tick = (m_div == TB_DIV - 1);
    endfunction

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        int last;
        reset = 1'b1;
        start = 1'b0;
        btn   = 4'd0;
        cyc();
        cyc();
        n_total++;
        if ({mole, score, time_left, playing, game_over, tick} !== 27'd0) begin
            n_bad++;
            $display("FAIL reset_vals: got %h want 0", {mole, score, time_left, playing, game_over, tick});
        end
        reset = 1'b0;
        last = -1;
        for (int i = 0; i < 40; i++) begin
            cyc();
            n_total++;
            if (tick !== m_tick || mole !== 4'd0 || playing !== 1'b0 || score !== 8'd0) begin
                n_bad++;
                $display("FAIL idle_cycle%0d: tick=%b mole=%h playing=%b score=%0d want tick=%b 0 0 0",
                         i, tick, mole, playing, score, m_tick);
            end
            if (tick === 1'b1) begin
                if (last >= 0) begin
                    n_total++;
                    if (i - last != TB_DIV) begin
                        n_bad++;
                        $display("FAIL tick_period: got %0d want %0d", i - last, TB_DIV);
                    end
                end
                last = i;
            end
        end
    endtask

    task automatic test_start();
        int ticks;
        int k;
        start = 1'b1;
        cyc();
        start = 1'b0;
        n_total++;
        if (playing !== 1'b1 || time_left !== 12'd20 || score !== 8'd0 || game_over !== 1'b0) begin
            n_bad++;
            $display("FAIL start_load: playing=%b time=%0d score=%0d over=%b want 1 20 0 0",
                     playing, time_left, score, game_over);
        end
        ticks = 0;
        k = 0;
        while (mole === 4'd0 && k < 100) begin
            if (tick === 1'b1) ticks++;
            cyc();
            k++;
        end
        n_total++;
        if (ticks != TB_GAP || !$onehot(mole) || mole !== m_mole) begin
            n_bad++;
            $display("FAIL first_mole: ticks=%0d mole=%h want ticks=%0d mole=%h", ticks, mole, TB_GAP, m_mole);
        end
    endtask

    task automatic test_hit();
        int ticks;
        int k;
        btn = m_mole;
        cyc();
        btn = 4'd0;
        n_total++;
        if (mole !== 4'd0 || score !== 8'd1) begin
            n_bad++;
            $display("FAIL hit_score: mole=%h score=%0d want 0 1", mole, score);
        end
        ticks = 0;
        k = 0;
        while (mole === 4'd0 && k < 100) begin
            if (tick === 1'b1) ticks++;
            cyc();
            k++;
        end
        n_total++;
        if (ticks != TB_GAP || mole !== m_mole || mole === 4'd0) begin
            n_bad++;
            $display("FAIL next_mole: ticks=%0d mole=%h want ticks=%0d mole=%h", ticks, mole, TB_GAP, m_mole);
        end
    endtask

    task automatic test_wrong_btn();
        int ticks;
        int k;
        logic [3:0] lit;
        lit = m_mole;
        ticks = 0;
        if (tick === 1'b1) ticks++;
        btn = ~lit;
        cyc();
        btn = 4'd0;
        n_total++;
        if (score !== 8'd1 || mole !== lit) begin
            n_bad++;
            $display("FAIL wrong_btn: score=%0d mole=%h want 1 %h", score, mole, lit);
        end
        k = 0;
        while (mole !== 4'd0 && k < 100) begin
            if (tick === 1'b1) ticks++;
            cyc();
            k++;
        end
        n_total++;
        if (ticks != TB_MOLE || mole !== 4'd0) begin
            n_bad++;
            $display("FAIL mole_timeout: ticks=%0d mole=%h want ticks=%0d mole=0", ticks, mole, TB_MOLE);
        end
        btn = 4'hF;
        cyc();
        btn = 4'd0;
        n_total++;
        if (score !== 8'd1 || mole !== 4'd0) begin
            n_bad++;
            $display("FAIL gap_btn: score=%0d mole=%h want 1 0", score, mole);
        end
    endtask

    task automatic test_final_hit();
        bit fin;
        bit seen;
        int psc;
        seen = 1'b0;
        for (int k = 0; k < 200 && game_over !== 1'b1; k++) begin
            fin = 1'b0;
            btn = 4'd0;
            if (m_phase == P_SHOW) begin
                if (m_time == 1) begin
                    if (m_tick) begin
                        btn = m_mole;
                        fin = 1'b1;
                    end
                end else if ((m_time % 2 == 1) && !m_tick) begin
                    btn = m_mole;
                end
            end
            psc = m_score;
            cyc();
            btn = 4'd0;
            if (fin) begin
                seen = 1'b1;
                n_total++;
                if (score !== 8'(psc + 1)) begin
                    n_bad++;
                    $display("FAIL final_hit_score: got %0d want %0d", score, psc + 1);
                end
            end
        end
        n_total++;
        if (!seen || game_over !== 1'b1 || mole !== 4'd0 || time_left !== 12'd0 || playing !== 1'b0) begin
            n_bad++;
            $display("FAIL round_over: seen=%b over=%b mole=%h time=%0d playing=%b want 1 1 0 0 0",
                     seen, game_over, mole, time_left, playing);
        end
        start = 1'b1;
        cyc();
        start = 1'b0;
        n_total++;
        if (score !== 8'd0 || playing !== 1'b1 || game_over !== 1'b0 || time_left !== 12'd20) begin
            n_bad++;
            $display("FAIL restart: score=%0d playing=%b over=%b time=%0d want 0 1 0 20",
                     score, playing, game_over, time_left);
        end
    endtask

    task automatic test_random();
        int r;
        logic [26:0] got;
        logic [26:0] exp;
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 299) == 0);
            start = ($urandom_range(0, 24) == 0);
            r = $urandom_range(0, 3);
            btn = (r == 0) ? m_mole : (r == 1) ? 4'($urandom) : 4'd0;
            cyc();
            got = {mole, score, time_left, playing, game_over, tick};
            exp = {m_mole, 8'(m_score), 12'(m_time), (m_phase == P_GAP || m_phase == P_SHOW),
                   (m_phase == P_OVER), m_tick};
            n_total++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL random_cycle%0d: got %h want %h", i, got, exp);
            end
        end
        reset = 1'b0;
        start = 1'b0;
        btn   = 4'd0;
    endtask

    task automatic test_saturate();
        int hits;
        int k;
        int want;
        rst2 = 1'b1;
        cyc();
        rst2 = 1'b0;
        start2 = 1'b1;
        cyc();
        start2 = 1'b0;
        hits = 0;
        k = 0;
        while (hits < 256 && k < 5000) begin
            if (mole2 !== 8'd0) begin
                btn2 = mole2;
                cyc();
                btn2 = 8'd0;
                hits++;
                want = (hits > 255) ? 255 : hits;
                n_total++;
                if (score2 !== 8'(want) || mole2 !== 8'd0) begin
                    n_bad++;
                    $display("FAIL sat_hit%0d: score=%0d mole=%h want %0d 0", hits, score2, mole2, want);
                end
            end else begin
                cyc();
            end
            k++;
        end
        n_total++;
        if (hits != 256 || score2 !== 8'd255) begin
            n_bad++;
            $display("FAIL sat_hold: hits=%0d score=%0d want 256 255", hits, score2);
        end
        k = 0;
        while (mole2 === 8'd0 && k < 100) begin
            cyc();
            k++;
        end
        n_total++;
        if (!$onehot(mole2) || playing2 !== 1'b1) begin
            n_bad++;
            $display("FAIL sat_show: mole=%h playing=%b want one-hot 1", mole2, playing2);
        end
        rst2 = 1'b1;
        cyc();
        rst2 = 1'b0;
        n_total++;
        if ({mole2, score2, time2, playing2, over2, tick2} !== 31'd0) begin
            n_bad++;
            $display("FAIL reset_mid_show: got %h want 0", {mole2, score2, time2, playing2, over2, tick2});
        end
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        reset   = 1'b1;
        start   = 1'b0;
        btn     = 4'd0;
        rst2    = 1'b1;
        start2  = 1'b0;
        btn2    = 8'd0;
        test_reset();
        test_start();
        test_hit();
        test_wrong_btn();
        test_final_hit();
        test_random();
        test_saturate();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
